// File: rtl/csa_resolver_pkg.sv
// Shared types and helpers for the carry-save resolver.
package csa_resolver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK_LEN-bit slices needed to cover a BIT_LEN-bit word.
    function automatic int chunk_count(input int bit_len, input int chunk_len);
        return bit_len / chunk_len;
    endfunction

endpackage

// File: rtl/csa_resolver_chunk.sv
// CHUNK_LEN-bit ripple-carry adder built from a chain of full adders.
module chunk_ripple_adder #(
    parameter int CHUNK_LEN = 4
) (
    input  logic [CHUNK_LEN-1:0] a,
    input  logic [CHUNK_LEN-1:0] b,
    input  logic                 cin,
    output logic [CHUNK_LEN-1:0] s,
    output logic                 cout
);

    logic [CHUNK_LEN:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[CHUNK_LEN];

    for (genvar i = 0; i < CHUNK_LEN; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the leaf cell of the chunk ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (S, C) pair into a binary sum, one chunk per cycle,
// so the final carry-propagate addition never spans the full word at once.
module csa_resolver
    import csa_resolver_pkg::*;
#(
    parameter int BIT_LEN   = 16,
    parameter int CHUNK_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] S,
    input  logic [BIT_LEN-1:0] C,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] sum,
    output logic               carry_out
);

    localparam int NUM_CHUNKS = chunk_count(BIT_LEN, CHUNK_LEN);
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    if (BIT_LEN % CHUNK_LEN != 0) begin : g_bad_chunk
        $error("csa_resolver: BIT_LEN must be a multiple of CHUNK_LEN");
    end

    state_t               state;
    state_t               next_state;
    logic [BIT_LEN-1:0]   s_reg;
    logic [BIT_LEN-1:0]   c_reg;
    logic [BIT_LEN-1:0]   sum_reg;
    logic                 carry_out_reg;
    logic                 run_carry;
    logic [IDX_W-1:0]     chunk_idx;
    logic [CHUNK_LEN-1:0] a_chunk;
    logic [CHUNK_LEN-1:0] b_chunk;
    logic [CHUNK_LEN-1:0] chunk_sum;
    logic                 chunk_cout;
    logic                 last_chunk;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign sum        = sum_reg;
    assign carry_out  = carry_out_reg;
    assign last_chunk = (chunk_idx == IDX_W'(NUM_CHUNKS - 1));

    // Select the operand slices for the chunk currently being resolved.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (chunk_idx == IDX_W'(i)) begin
                a_chunk = s_reg[i*CHUNK_LEN +: CHUNK_LEN];
                b_chunk = c_reg[i*CHUNK_LEN +: CHUNK_LEN];
            end
        end
    end

    chunk_ripple_adder #(
        .CHUNK_LEN (CHUNK_LEN)
    ) u_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (run_carry),
        .s    (chunk_sum),
        .cout (chunk_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: accept in IDLE, walk the chunks in BUSY, hold in DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = BUSY;
            BUSY: if (last_chunk) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, per-chunk result write-back and running carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg         <= '0;
            c_reg         <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            run_carry     <= 1'b0;
            chunk_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_reg     <= S;
                        c_reg     <= C;
                        chunk_idx <= '0;
                        run_carry <= 1'b0;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < NUM_CHUNKS; i++) begin
                        if (chunk_idx == IDX_W'(i)) begin
                            sum_reg[i*CHUNK_LEN +: CHUNK_LEN] <= chunk_sum;
                        end
                    end
                    run_carry <= chunk_cout;
                    chunk_idx <= chunk_idx + 1'b1;
                    if (last_chunk) begin
                        carry_out_reg <= chunk_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and streaming checks for csa_resolver with BIT_LEN=16, CHUNK_LEN=4.
module tb_csa_resolver;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] S;
    logic [15:0] C;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry_out;

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;

    csa_resolver #(
        .BIT_LEN   (16),
        .CHUNK_LEN (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used to measure throughput.
    always @(posedge clk) cyc <= cyc + 1;

    // Present operands until the handshake edge; leaves time at edge+1.
    task automatic accept(input logic [15:0] s_in, input logic [15:0] c_in, output bit ok);
        bit hs;
        ok = 1'b0;
        in_valid = 1'b1;
        S = s_in;
        C = c_in;
        for (int i = 0; i < 30; i++) begin
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Count edges until out_valid rises, bounded.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        bit ok;
        int cycles;
        $display("[TB] test_reset");
        check_count++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else pass_count++;
        check_count++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else pass_count++;
        check_count++;
        if ({carry_out, sum} !== 17'h0) $display("[TB] FAIL reset_sum: got %b_%h expected 0_0000", carry_out, sum); else pass_count++;
        out_ready = 1'b0;
        accept(16'hFFFF, 16'h0001, ok);
        in_valid = 1'b0;
        wait_valid(cycles);
        check_count++;
        if (out_valid !== 1'b1) $display("[TB] FAIL pre_reset_valid: got %b expected 1", out_valid); else pass_count++;
        #2 rst_n = 1'b0;
        #1;
        check_count++;
        if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL async_reset_hs: got %b expected 01", {out_valid, in_ready}); else pass_count++;
        check_count++;
        if ({carry_out, sum} !== 17'h0) $display("[TB] FAIL async_reset_sum: got %b_%h expected 0_0000", carry_out, sum); else pass_count++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_cross_chunk;
        bit ok;
        int cycles;
        $display("[TB] test_cross_chunk");
        out_ready = 1'b1;
        accept(16'h00FF, 16'h0001, ok);
        in_valid = 1'b0;
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL cross_accept: got %b expected 1", ok); else pass_count++;
        wait_valid(cycles);
        check_count++;
        if (cycles != 4) $display("[TB] FAIL cross_latency: got %0d expected 4", cycles); else pass_count++;
        check_count++;
        if ({carry_out, sum} !== {1'b0, 16'h0100}) $display("[TB] FAIL cross_sum: got %b_%h expected 0_0100", carry_out, sum); else pass_count++;
    endtask

    task automatic test_overflow;
        bit ok;
        int cycles;
        $display("[TB] test_overflow");
        out_ready = 1'b1;
        accept(16'hFFFF, 16'h0001, ok);
        in_valid = 1'b0;
        wait_valid(cycles);
        check_count++;
        if ({carry_out, sum} !== {1'b1, 16'h0000} || cycles != 4)
            $display("[TB] FAIL overflow_sum: got %b_%h after %0d expected 1_0000 after 4", carry_out, sum, cycles);
        else pass_count++;
        accept(16'h1234, 16'h4321, ok);
        in_valid = 1'b0;
        wait_valid(cycles);
        check_count++;
        if ({carry_out, sum} !== {1'b0, 16'h5555} || cycles != 4)
            $display("[TB] FAIL plain_sum: got %b_%h after %0d expected 0_5555 after 4", carry_out, sum, cycles);
        else pass_count++;
    endtask

    task automatic test_backpressure;
        bit ok;
        int cycles;
        $display("[TB] test_backpressure");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        accept(16'h0F00, 16'h0100, ok);
        wait_valid(cycles);
        check_count++;
        if ({out_valid, carry_out, sum} !== {2'b10, 16'h1000}) $display("[TB] FAIL bp_first: got %b_%b_%h expected 1_0_1000", out_valid, carry_out, sum); else pass_count++;
        in_valid = 1'b1;
        S = 16'hAAAA;
        C = 16'h1111;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_count++;
            if ({out_valid, in_ready, carry_out, sum} !== {3'b100, 16'h1000})
                $display("[TB] FAIL bp_hold: cycle %0d got v%b r%b %b_%h expected v1 r0 0_1000", i, out_valid, in_ready, carry_out, sum);
            else pass_count++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_count++;
        if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL bp_release: got %b expected 01", {out_valid, in_ready}); else pass_count++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_count++;
        if (in_ready !== 1'b0) $display("[TB] FAIL bp_late_accept: got %b expected 0", in_ready); else pass_count++;
        wait_valid(cycles);
        check_count++;
        if ({carry_out, sum} !== {1'b0, 16'hBBBB} || cycles != 4)
            $display("[TB] FAIL bp_second: got %b_%h after %0d expected 0_bbbb after 4", carry_out, sum, cycles);
        else pass_count++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        int cycles;
        $display("[TB] test_reset_mid");
        out_ready = 1'b1;
        accept(16'h1111, 16'h2222, ok);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_count++;
        if (seen !== 1'b0) $display("[TB] FAIL abort_no_valid: got %b expected 0", seen); else pass_count++;
        accept(16'h0F0F, 16'h00F1, ok);
        in_valid = 1'b0;
        wait_valid(cycles);
        check_count++;
        if ({carry_out, sum} !== {1'b0, 16'h1000} || cycles != 4)
            $display("[TB] FAIL after_abort: got %b_%h after %0d expected 0_1000 after 4", carry_out, sum, cycles);
        else pass_count++;
    endtask

    task automatic test_streaming;
        bit ok;
        int cycles;
        int last_acc;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] expv;
        $display("[TB] test_streaming");
        out_ready = 1'b1;
        last_acc = 0;
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            expv = {1'b0, a} + {1'b0, b};
            accept(a, b, ok);
            if (n > 0) begin
                check_count++;
                if (cyc - last_acc != 6) $display("[TB] FAIL stream_gap: n=%0d got %0d expected 6", n, cyc - last_acc); else pass_count++;
            end
            last_acc = cyc;
            S = 16'($urandom);
            C = 16'($urandom);
            wait_valid(cycles);
            check_count++;
            if ({carry_out, sum} !== expv || cycles != 4)
                $display("[TB] FAIL stream_sum: n=%0d %h+%h got %b_%h after %0d expected %h after 4", n, a, b, carry_out, sum, cycles, expv);
            else pass_count++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        S         = '0;
        C         = '0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_cross_chunk();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_streaming();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
